// File: rtl/l1_block_cache.sv
`default_nettype none
// ----------------------------------------------------------------------------
// l1_block_cache: N-port fully associative block cache, single-outstanding miss/fill.
// L1_CACHE_PLRU_EN selects tree pseudo-LRU replacement (default: cyclic). Rev 1.0
// ----------------------------------------------------------------------------
module l1_block_cache #(
  parameter int N_PORTS = 4,
  parameter int DEPTH   = 16,
  parameter int POS_W   = 24,
  parameter int BLOCK_W = 8,
  parameter logic [BLOCK_W-1:0] BLOCK_AIR = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [N_PORTS-1:0]         req_valid_in,
  input  logic [N_PORTS*POS_W-1:0]   req_pos_in,
  output logic [N_PORTS-1:0]         hit_out,
  output logic [N_PORTS*BLOCK_W-1:0] block_out,
  output logic                       miss_valid_out,
  output logic [POS_W-1:0]           miss_pos_out,
  input  logic                       miss_ready_in,
  input  logic                       fill_valid_in,
  input  logic [POS_W-1:0]           fill_pos_in,
  input  logic [BLOCK_W-1:0]         fill_block_in,
  input  logic                       inval_in,
  output logic                       busy_out
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  state_t state, state_next;

  logic [DEPTH-1:0]   valid;
  logic [POS_W-1:0]   tag  [DEPTH];
  logic [BLOCK_W-1:0] data [DEPTH];

  logic [N_PORTS-1:0] port_hit, port_miss;
  logic [BLOCK_W-1:0] port_data [N_PORTS];
  logic [PW-1:0]      rr_ptr, sel_port, rr_next;
  logic [POS_W-1:0]   miss_pos;

  // Tags are unique, so OR-ing the matching entries' data is a one-hot mux.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      port_hit[p]  = 1'b0;
      port_data[p] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (valid[e] && tag[e] == req_pos_in[p*POS_W +: POS_W]) begin
          port_hit[p]  = 1'b1;
          port_data[p] = port_data[p] | data[e];
        end
      end
      port_miss[p] = req_valid_in[p] && !port_hit[p];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_out   <= '0;
      block_out <= {N_PORTS{BLOCK_AIR}};
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        hit_out[p] <= req_valid_in[p] && port_hit[p];
        block_out[p*BLOCK_W +: BLOCK_W] <= (req_valid_in[p] && port_hit[p]) ? port_data[p] : BLOCK_AIR;
      end
    end
  end

  // Fill target: existing copy first, then lowest invalid slot, then policy victim.
  logic          fill_hit, any_invalid, fill_take;
  logic [IW-1:0] fill_hit_idx, first_invalid, fill_idx, repl_victim;

  always_comb begin
    fill_hit      = 1'b0;
    fill_hit_idx  = '0;
    any_invalid   = 1'b0;
    first_invalid = '0;
    for (int e = DEPTH-1; e >= 0; e--) begin
      if (valid[e] && tag[e] == fill_pos_in) begin
        fill_hit     = 1'b1;
        fill_hit_idx = IW'(e);
      end
      if (!valid[e]) begin
        any_invalid   = 1'b1;
        first_invalid = IW'(e);
      end
    end
  end

  assign fill_take = fill_valid_in && !inval_in;
  assign fill_idx  = fill_hit ? fill_hit_idx : (any_invalid ? first_invalid : repl_victim);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     valid <= '0;
    else if (inval_in) valid <= '0;
    else if (fill_take) valid[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (fill_take) begin
      tag[fill_idx]  <= fill_pos_in;
      data[fill_idx] <= fill_block_in;
    end
  end

`ifdef L1_CACHE_PLRU_EN
  logic [IW-1:0]    port_idx [N_PORTS];
  logic [DEPTH-2:0] plru, plru_next;

  // Each node bit points toward the less recently used half of its subtree.
  function automatic logic [DEPTH-2:0] plru_touch(input logic [DEPTH-2:0] t, input logic [IW-1:0] idx);
    int   n;
    logic b;
    plru_touch = t;
    n = 1;
    for (int l = 0; l < IW; l++) begin
      b = idx[IW-1-l];
      plru_touch[n-1] = ~b;
      n = 2*n + int'(b);
    end
  endfunction

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      port_idx[p] = '0;
      for (int e = 0; e < DEPTH; e++)
        if (valid[e] && tag[e] == req_pos_in[p*POS_W +: POS_W]) port_idx[p] = IW'(e);
    end
  end

  always_comb begin
    plru_next = plru;
    for (int p = N_PORTS-1; p >= 0; p--)
      if (req_valid_in[p] && port_hit[p]) plru_next = plru_touch(plru_next, port_idx[p]);
    if (fill_take) plru_next = plru_touch(plru_next, fill_idx);
  end

  always_comb begin
    int n;
    n = 1;
    repl_victim = '0;
    for (int l = 0; l < IW; l++) begin
      repl_victim[IW-1-l] = plru[n-1];
      n = 2*n + int'(plru[n-1]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     plru <= '0;
    else if (inval_in) plru <= '0;
    else               plru <= plru_next;
  end
`else
  logic [IW-1:0] repl_ptr;

  assign repl_victim = repl_ptr;

  // Only evictions advance the pointer; filling free slots leaves it in place.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     repl_ptr <= '0;
    else if (inval_in) repl_ptr <= '0;
    else if (fill_take && !fill_hit && !any_invalid) repl_ptr <= repl_ptr + 1'b1;
  end
`endif

  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    sel_port = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && port_miss[idx]) begin
        found    = 1'b1;
        sel_port = PW'(idx);
      end
    end
  end

  assign rr_next = (int'(sel_port) == N_PORTS-1) ? '0 : sel_port + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|port_miss) state_next = REQ;
      REQ:     if (miss_ready_in) state_next = WAIT;
      WAIT:    if (fill_valid_in && fill_pos_in == miss_pos) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      miss_pos <= '0;
      rr_ptr   <= '0;
    end else if (state == IDLE && |port_miss) begin
      miss_pos <= req_pos_in[int'(sel_port)*POS_W +: POS_W];
      rr_ptr   <= rr_next;
    end
  end

  assign miss_valid_out = (state == REQ);
  assign miss_pos_out   = miss_pos;
  assign busy_out       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_l1_block_cache.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_l1_block_cache: scenario tasks plus randomized traffic against a slot-level cache model.
// ----------------------------------------------------------------------------
module tb_l1_block_cache;
  localparam int D = 16;
  localparam logic [7:0] AIR   = 8'd0;
  localparam logic [7:0] STONE = 8'd1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid;
  logic [95:0]  req_pos;
  logic [3:0]   hit;
  logic [31:0]  blk;
  logic         miss_valid;
  logic [23:0]  miss_pos;
  logic         miss_ready, fill_valid, inval, busy;
  logic [23:0]  fill_pos;
  logic [7:0]   fill_block;

  int checks = 0;
  int passed = 0;

  // Reference: DEPTH slots, cyclic victim pointer advanced only on evictions.
  logic        m_valid [D];
  logic [23:0] m_pos   [D];
  logic [7:0]  m_data  [D];
  int          m_ptr;

  l1_block_cache #(.N_PORTS(4), .DEPTH(D), .POS_W(24), .BLOCK_W(8), .BLOCK_AIR(8'd0)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_pos_in(req_pos),
    .hit_out(hit), .block_out(blk),
    .miss_valid_out(miss_valid), .miss_pos_out(miss_pos), .miss_ready_in(miss_ready),
    .fill_valid_in(fill_valid), .fill_pos_in(fill_pos), .fill_block_in(fill_block),
    .inval_in(inval), .busy_out(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] pos(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    return {x, y, z};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_inval();
    for (int e = 0; e < D; e++) m_valid[e] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic model_fill(input logic [23:0] p, input logic [7:0] d);
    int slot;
    slot = -1;
    for (int e = 0; e < D; e++) if (m_valid[e] && m_pos[e] == p) slot = e;
    if (slot >= 0) begin
      m_data[slot] = d;
    end else begin
      for (int e = D-1; e >= 0; e--) if (!m_valid[e]) slot = e;
      if (slot < 0) begin
        slot  = m_ptr;
        m_ptr = (m_ptr + 1) % D;
      end
      m_valid[slot] = 1'b1;
      m_pos[slot]   = p;
      m_data[slot]  = d;
    end
  endtask

  function automatic logic model_hit(input logic [23:0] p, output logic [7:0] d);
    d = AIR;
    for (int e = 0; e < D; e++)
      if (m_valid[e] && m_pos[e] == p) begin
        d = m_data[e];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    req_valid  = '0;
    req_pos    = '0;
    miss_ready = 1'b0;
    fill_valid = 1'b0;
    fill_pos   = '0;
    fill_block = '0;
    inval      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_inval();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (hit !== 4'b0) $display("FAIL reset_hit got %b want 0000", hit); else passed++;
    checks++; if (blk !== {4{AIR}}) $display("FAIL reset_block got %h want %h", blk, {4{AIR}}); else passed++;
    checks++; if (miss_valid !== 1'b0) $display("FAIL reset_miss_valid got %b want 0", miss_valid); else passed++;
    checks++; if (miss_pos !== 24'h0) $display("FAIL reset_miss_pos got %h want 0", miss_pos); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_miss_request();
    logic [23:0] p;
    p = pos(1, 2, 3);
    do_reset();
    req_valid = 4'b0001;
    req_pos[23:0] = p;
    tick();
    req_valid = '0;
    checks++; if (hit[0] !== 1'b0) $display("FAIL miss_hit0 got %b want 0", hit[0]); else passed++;
    checks++; if (blk[7:0] !== AIR) $display("FAIL miss_block0 got %h want %h", blk[7:0], AIR); else passed++;
    checks++; if (miss_valid !== 1'b1) $display("FAIL miss_valid_rise got %b want 1", miss_valid); else passed++;
    checks++; if (miss_pos !== p) $display("FAIL miss_pos got %h want %h", miss_pos, p); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (miss_valid !== 1'b1 || miss_pos !== p)
        $display("FAIL miss_hold cycle %0d got valid=%b pos=%h want valid=1 pos=%h", i, miss_valid, miss_pos, p);
      else passed++;
    end
    miss_ready = 1'b1;
    tick();
    miss_ready = 1'b0;
    checks++; if (miss_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL handshake_wait got valid=%b busy=%b want valid=0 busy=1", miss_valid, busy);
    else passed++;
    fill_valid = 1'b1; fill_pos = p; fill_block = STONE;
    tick();
    fill_valid = 1'b0;
    model_fill(p, STONE);
    checks++; if (busy !== 1'b0) $display("FAIL fill_idle busy got %b want 0", busy); else passed++;
    req_valid = 4'hF;
    req_pos   = {4{p}};
    tick();
    req_valid = '0;
    checks++; if (hit !== 4'b1111) $display("FAIL allport_hit got %b want 1111", hit); else passed++;
    checks++; if (blk !== {4{STONE}}) $display("FAIL allport_block got %h want %h", blk, {4{STONE}}); else passed++;
  endtask

  task automatic test_round_robin();
    logic [23:0] exp_pos [5];
    int n;
    do_reset();
    for (int k = 0; k < 4; k++) exp_pos[k] = pos(8'(10 + k), 0, 0);
    exp_pos[4] = pos(20, 0, 0);
    req_valid = 4'hF;
    for (int p = 0; p < 4; p++) req_pos[p*24 +: 24] = exp_pos[p];
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!miss_valid && n < 20) begin
        tick();
        n++;
      end
      checks++; if (miss_valid !== 1'b1) $display("FAIL rr_timeout issue %0d got valid=%b want 1", k, miss_valid); else passed++;
      checks++; if (miss_pos !== exp_pos[k]) $display("FAIL rr_order issue %0d got %h want %h", k, miss_pos, exp_pos[k]); else passed++;
      miss_ready = 1'b1;
      tick();
      miss_ready = 1'b0;
      fill_valid = 1'b1; fill_pos = exp_pos[k]; fill_block = 8'(k + 2);
      tick();
      fill_valid = 1'b0;
      model_fill(exp_pos[k], 8'(k + 2));
      // Port 0 keeps missing on a fresh position, so a fixed-priority arbiter would jump the queue.
      if (k == 0) req_pos[23:0] = exp_pos[4];
    end
    req_valid = '0;
  endtask

  task automatic test_replacement();
    logic [23:0] r [17];
    logic [7:0]  dv [17];
    int i;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      r[k]  = pos(0, 8'(k + 1), 7);
      dv[k] = 8'($urandom_range(2, 255));
      fill_valid = 1'b1; fill_pos = r[k]; fill_block = dv[k];
      tick();
    end
    fill_valid = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        dv[5] = ~dv[5];
        fill_valid = 1'b1; fill_pos = r[5]; fill_block = dv[5];
        tick();
        fill_valid = 1'b0;
      end
      for (int g = 0; g < 17; g += 4) begin
        req_valid = '0;
        for (int p = 0; p < 4; p++)
          if (g + p < 17) begin
            req_valid[p] = 1'b1;
            req_pos[p*24 +: 24] = r[g+p];
          end
        tick();
        for (int p = 0; p < 4; p++) begin
          i = g + p;
          if (i < 17) begin
            checks++;
            if (hit[p] !== (i != 0) || blk[p*8 +: 8] !== ((i != 0) ? dv[i] : AIR))
              $display("FAIL evict pass %0d pos %0d got hit=%b blk=%h want hit=%b blk=%h",
                       pass, i + 1, hit[p], blk[p*8 +: 8], (i != 0), (i != 0) ? dv[i] : AIR);
            else passed++;
          end
        end
      end
      req_valid = '0;
    end
  endtask

  task automatic test_inval_wait();
    logic [23:0] a, b, c;
    a = pos(9, 9, 9); b = pos(5, 5, 5); c = pos(6, 6, 6);
    do_reset();
    fill_valid = 1'b1; fill_pos = b; fill_block = 8'h11;
    tick();
    fill_pos = c; fill_block = 8'h22;
    tick();
    fill_valid = 1'b0;
    req_valid = 4'b0001; req_pos[23:0] = a;
    tick();
    req_valid = '0;
    miss_ready = 1'b1;
    tick();
    miss_ready = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL inval_pre_wait busy got %b want 1", busy); else passed++;
    inval = 1'b1;
    tick();
    inval = 1'b0;
    req_valid = 4'hF;
    req_pos   = {b, c, a, b};
    tick();
    req_valid = '0;
    checks++; if (hit !== 4'b0000) $display("FAIL inval_all_miss got %b want 0000", hit); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL inval_keeps_wait busy got %b want 1", busy); else passed++;
    fill_valid = 1'b1; fill_pos = a; fill_block = 8'h33;
    tick();
    fill_valid = 1'b0;
    checks++; if (busy !== 1'b0 || miss_valid !== 1'b0)
      $display("FAIL inval_fill_idle got busy=%b valid=%b want 0 0", busy, miss_valid);
    else passed++;
    req_valid = 4'b0101;
    req_pos[23:0]  = b;
    req_pos[71:48] = a;
    tick();
    req_valid = '0;
    checks++; if (hit[2] !== 1'b1 || blk[23:16] !== 8'h33)
      $display("FAIL inval_refill got hit=%b blk=%h want hit=1 blk=33", hit[2], blk[23:16]);
    else passed++;
    checks++; if (hit[0] !== 1'b0) $display("FAIL inval_stale got hit=%b want 0", hit[0]); else passed++;
  endtask

  task automatic test_random();
    logic [3:0]  exp_hit;
    logic [31:0] exp_blk;
    logic [7:0]  d;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int p = 0; p < 4; p++) begin
        req_valid[p] = 1'($urandom_range(0, 1));
        req_pos[p*24 +: 24] = pos(8'($urandom_range(0, 23)), 1, 1);
      end
      fill_valid = ($urandom_range(0, 2) == 0);
      fill_pos   = pos(8'($urandom_range(0, 23)), 1, 1);
      fill_block = 8'($urandom);
      inval      = ($urandom_range(0, 29) == 0);
      miss_ready = 1'($urandom_range(0, 1));
      for (int p = 0; p < 4; p++) begin
        exp_hit[p] = req_valid[p] && model_hit(req_pos[p*24 +: 24], d);
        exp_blk[p*8 +: 8] = exp_hit[p] ? d : AIR;
      end
      tick();
      if (inval) model_inval();
      else if (fill_valid) model_fill(fill_pos, fill_block);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (hit[p] !== exp_hit[p] || blk[p*8 +: 8] !== exp_blk[p*8 +: 8])
          $display("FAIL random cyc %0d port %0d got hit=%b blk=%h want hit=%b blk=%h",
                   cyc, p, hit[p], blk[p*8 +: 8], exp_hit[p], exp_blk[p*8 +: 8]);
        else passed++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b0001; req_pos[23:0] = pos(1, 1, 1);
    tick();
    req_valid = '0;
    checks++; if (miss_valid !== 1'b1) $display("FAIL async_pre got valid=%b want 1", miss_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (miss_valid !== 1'b0 || busy !== 1'b0 || miss_pos !== 24'h0)
      $display("FAIL async_reset got valid=%b busy=%b pos=%h want 0 0 000000", miss_valid, busy, miss_pos);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_inval();
    tick();
  endtask

  initial begin
    clear_inputs();
    for (int e = 0; e < D; e++) begin
      m_pos[e]  = '0;
      m_data[e] = '0;
    end
    model_inval();
    test_reset();
    test_miss_request();
    test_round_robin();
    test_replacement();
    test_inval_wait();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
